// File: rtl/cache_assoc_rd.sv
// N-way set-associative read cache. Hits are answered the cycle after
// acceptance; misses fetch a whole line as a burst of valid-only beats,
// then answer from the freshly filled line. Victims are the lowest invalid
// way, otherwise the set's round-robin pointer.
module cache_assoc_rd #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SETS        = 16,
    parameter int WAYS        = 2,
    parameter int BLOCK_WORDS = 4
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iReq,
    input  logic [ADDR_W-1:0] iAddress,
    output logic              oReady,
    output logic              oValid,
    output logic [DATA_W-1:0] oData,
    output logic              oHit,
    input  logic              iFlush,
    input  logic              iFlushAll,
    input  logic [ADDR_W-1:0] iFlushAddress,
    output logic              oFlushAck,
    output logic              oMemReq,
    output logic [ADDR_W-1:0] oMemAddr,
    input  logic              iMemValid,
    input  logic [DATA_W-1:0] iMemData
);

    localparam int WO  = $clog2(BLOCK_WORDS);
    localparam int IX  = $clog2(SETS);
    localparam int TW  = ADDR_W - 2 - WO - IX;
    localparam int WOW = (WO > 0) ? WO : 1;
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {IDLE, COMPARE, REFILL, RESPOND} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WOW-1:0]    beat_q, beat_d;
    logic [WW-1:0]     victim_q, victim_d;
    logic [WAYS-1:0]   valid_q [SETS];
    logic [WAYS-1:0]   valid_d [SETS];
    logic [TW-1:0]     tag_q   [SETS][WAYS];
    logic [TW-1:0]     tag_d   [SETS][WAYS];
    logic [WW-1:0]     ptr_q   [SETS];
    logic [WW-1:0]     ptr_d   [SETS];
    logic [DATA_W-1:0] data_q  [SETS][WAYS][BLOCK_WORDS];
    logic              data_we;

    logic [IX-1:0]     req_set, flush_set;
    logic [TW-1:0]     req_tag, flush_tag;
    logic [WOW-1:0]    req_wo;
    logic              hit_any, hit_multi, inv_any;
    logic [WW-1:0]     hit_way, inv_way;
    logic              unused_bits;

    assign req_set     = addr_q[2+WO +: IX];
    assign req_tag     = addr_q[ADDR_W-1 -: TW];
    assign req_wo      = (WO > 0) ? addr_q[2 +: WOW] : '0;
    assign flush_set   = iFlushAddress[2+WO +: IX];
    assign flush_tag   = iFlushAddress[ADDR_W-1 -: TW];
    // Byte-offset and word-offset bits that never index anything.
    assign unused_bits = ^{addr_q[1:0], iFlushAddress[WO+1:0]};

    // Tag lookup on the registered request; the descending scan leaves the
    // lowest matching way and the lowest invalid way.
    always_comb begin
        hit_any   = 1'b0;
        hit_multi = 1'b0;
        hit_way   = '0;
        inv_any   = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[req_set][w]) begin
                inv_any = 1'b1;
                inv_way = WW'(w);
            end
            if (valid_q[req_set][w] && tag_q[req_set][w] == req_tag) begin
                if (hit_any) hit_multi = 1'b1;
                hit_any = 1'b1;
                hit_way = WW'(w);
            end
        end
    end

    // Next-state, metadata updates and outputs of the controller.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        beat_d    = beat_q;
        victim_d  = victim_q;
        valid_d   = valid_q;
        tag_d     = tag_q;
        ptr_d     = ptr_q;
        data_we   = 1'b0;
        oValid    = 1'b0;
        oHit      = 1'b0;
        oData     = '0;
        oFlushAck = 1'b0;
        oMemReq   = 1'b0;
        oMemAddr  = '0;
        oReady    = (state_q == IDLE) && !iFlush && !iFlushAll;
        case (state_q)
            IDLE: begin
                if (iFlushAll) begin
                    for (int s = 0; s < SETS; s++) valid_d[s] = '0;
                    oFlushAck = 1'b1;
                end else if (iFlush) begin
                    for (int w = 0; w < WAYS; w++)
                        if (valid_q[flush_set][w] && tag_q[flush_set][w] == flush_tag)
                            valid_d[flush_set][w] = 1'b0;
                    oFlushAck = 1'b1;
                end else if (iReq) begin
                    addr_d  = iAddress;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (hit_any && !hit_multi) begin
                    oValid  = 1'b1;
                    oHit    = 1'b1;
                    oData   = data_q[req_set][hit_way][req_wo];
                    state_d = IDLE;
                end else begin
                    victim_d = inv_any ? inv_way : ptr_q[req_set];
                    beat_d   = '0;
                    state_d  = REFILL;
                end
            end
            REFILL: begin
                oMemReq  = 1'b1;
                oMemAddr = {addr_q[ADDR_W-1:WO+2], (WO+2)'(0)};
                if (iMemValid) begin
                    data_we = 1'b1;
                    beat_d  = beat_q + WOW'(1);
                    if (beat_q == WOW'(BLOCK_WORDS - 1)) begin
                        tag_d[req_set][victim_q]   = req_tag;
                        valid_d[req_set][victim_q] = 1'b1;
                        ptr_d[req_set] = (WAYS > 1) ? ptr_q[req_set] + WW'(1) : '0;
                        beat_d  = '0;
                        state_d = RESPOND;
                    end
                end
            end
            RESPOND: begin
                oValid  = 1'b1;
                oData   = data_q[req_set][victim_q][req_wo];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and metadata registers; reset drops any partial refill.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            beat_q   <= '0;
            victim_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
                for (int w = 0; w < WAYS; w++) tag_q[s][w] <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            victim_q <= victim_d;
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            ptr_q    <= ptr_d;
        end
    end

    // Line data storage, written one beat at a time into the victim way.
    always_ff @(posedge iClk) begin
        if (iRst && data_we) data_q[req_set][victim_q][beat_q] <= iMemData;
    end

endmodule

// File: tb/tb_cache_assoc_rd.sv
// Bench for cache_assoc_rd: directed scenarios with literal expectations
// plus randomized reads/flushes, all checked against a set/way residency
// model and a fixed main-memory content function.
module tb_cache_assoc_rd;

    logic        iClk = 1'b0;
    logic        iRst, iReq, iFlush, iFlushAll, iMemValid;
    logic [31:0] iAddress, iFlushAddress, iMemData;
    logic        oReady, oValid, oHit, oFlushAck, oMemReq;
    logic [31:0] oData, oMemAddr;

    cache_assoc_rd dut (
        .iClk(iClk), .iRst(iRst), .iReq(iReq), .iAddress(iAddress),
        .oReady(oReady), .oValid(oValid), .oData(oData), .oHit(oHit),
        .iFlush(iFlush), .iFlushAll(iFlushAll), .iFlushAddress(iFlushAddress),
        .oFlushAck(oFlushAck), .oMemReq(oMemReq), .oMemAddr(oMemAddr),
        .iMemValid(iMemValid), .iMemData(iMemData)
    );

    always #5 iClk = ~iClk;

    // Main memory contents; line 0x040 holds the known pattern 0x11..0x44.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h40 && a <= 32'h4C) return 32'h11 * ((a - 32'h40) / 4 + 1);
        return (a * 32'h9E3779B1) ^ 32'h5A5A_0000;
    endfunction

    int n_cmp = 0;
    int n_bad = 0;

    // Literal expectations per issued read (written by director only).
    logic        lit_en [4096];
    logic [31:0] lit_d  [4096];
    logic        lit_h  [4096];
    logic [31:0] lit_m  [4096];   // expected refill address, or all-ones for none
    int          lwr = 0;

    // Responder controls (written by director only).
    int resp_gap   = -1;
    int beat_limit = -1;
    int late_req   = 0;
    int rcnt       = 0;

    // ---------------- compare process and model ----------------
    bit          m_valid [16][2];
    logic [23:0] m_tag   [16][2];
    int          m_ptr   [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        bit          pend, p_hit, p_len, resp_now, idle, just_rst, hit;
        logic [31:0] p_addr, p_data, p_ld, p_lm;
        logic        p_lh;
        int          age, cyc, lrd, v, s;
        pend = 0; just_rst = 0; cyc = 0; lrd = 0; age = 0;
        p_hit = 0; p_len = 0; p_addr = 0; p_data = 0; p_ld = 0; p_lm = 0; p_lh = 0;
        forever begin
            @(negedge iClk);
            cyc++;
            if (cyc > 60000) begin
                $display("FAIL watchdog: got %0d cycles expected under 60000", cyc);
                $fatal(1, "watchdog");
            end
            if (!iRst) begin
                for (int i = 0; i < 16; i++) begin
                    m_ptr[i] = 0;
                    for (int w = 0; w < 2; w++) m_valid[i][w] = 0;
                end
                pend = 0;
                just_rst = 1;
                continue;
            end
            resp_now = 0;
            if (just_rst) begin
                chk("rst_valid",   32'(oValid),  0);
                chk("rst_memreq",  32'(oMemReq), 0);
                chk("rst_data",    oData,        0);
                chk("rst_memaddr", oMemAddr,     0);
                just_rst = 0;
            end
            if (pend) age++;
            if (oValid) begin
                if (!pend) chk("spurious_valid", 32'(oValid), 0);
                else begin
                    chk("rd_data", oData, p_data);
                    chk("rd_hit", 32'(oHit), 32'(p_hit));
                    if (p_hit) chk("hit_latency", age, 1);
                    if (p_len) begin
                        chk("lit_data", oData, p_ld);
                        chk("lit_hit", 32'(oHit), 32'(p_lh));
                    end
                    pend = 0;
                end
                resp_now = 1;
            end else if (pend && age > 600) begin
                chk("resp_timeout", age, 0);
                pend = 0;
            end
            idle = !pend && !resp_now;
            chk("ready", 32'(oReady), 32'(idle && !iFlush && !iFlushAll));
            chk("flush_ack", 32'(oFlushAck), 32'(idle && (iFlush || iFlushAll)));
            if (!pend || p_hit) chk("memreq_off", 32'(oMemReq), 0);
            else if (oMemReq) begin
                chk("memaddr", oMemAddr, p_addr & ~32'hF);
                if (p_len && p_lm != 32'hFFFF_FFFF) chk("lit_memaddr", oMemAddr, p_lm);
            end
            if (idle) begin
                if (iFlushAll) begin
                    for (int i = 0; i < 16; i++)
                        for (int w = 0; w < 2; w++) m_valid[i][w] = 0;
                end else if (iFlush) begin
                    s = int'(iFlushAddress[7:4]);
                    for (int w = 0; w < 2; w++)
                        if (m_tag[s][w] == iFlushAddress[31:8]) m_valid[s][w] = 0;
                end else if (iReq) begin
                    s = int'(iAddress[7:4]);
                    hit = 0;
                    for (int w = 0; w < 2; w++)
                        if (m_valid[s][w] && m_tag[s][w] == iAddress[31:8]) hit = 1;
                    if (!hit) begin
                        v = -1;
                        for (int w = 0; w < 2; w++) if (!m_valid[s][w] && v < 0) v = w;
                        if (v < 0) v = m_ptr[s];
                        m_valid[s][v] = 1;
                        m_tag[s][v] = iAddress[31:8];
                        m_ptr[s] = (m_ptr[s] + 1) % 2;
                    end
                    pend = 1; age = 0; p_hit = hit; p_addr = iAddress;
                    p_data = mem_word({iAddress[31:2], 2'b00});
                    p_len = 0;
                    if (lrd < lwr) begin
                        p_len = lit_en[lrd]; p_ld = lit_d[lrd];
                        p_lh = lit_h[lrd]; p_lm = lit_m[lrd];
                        lrd++;
                    end
                end
            end
        end
    end

    // ---------------- memory responder ----------------
    initial begin
        int gap_left, late_done;
        gap_left = 0; late_done = 0;
        iMemValid = 1'b0;
        iMemData  = '0;
        forever begin
            @(negedge iClk);
            iMemValid = 1'b0;
            if (!iRst) begin
                rcnt = 0; gap_left = 0;
            end else if (!oMemReq) begin
                rcnt = 0; gap_left = 0;
                if (late_done < late_req) begin
                    late_done++;
                    iMemValid = 1'b1;
                    iMemData  = 32'hDEAD_BEEF;
                end
            end else if (gap_left > 0) begin
                gap_left--;
            end else if (rcnt < 4 && (beat_limit < 0 || rcnt < beat_limit)) begin
                iMemValid = 1'b1;
                iMemData  = mem_word(oMemAddr + 32'(4 * rcnt));
                rcnt++;
                gap_left = (resp_gap < 0) ? int'($urandom_range(0, 2)) : resp_gap;
            end
        end
    end

    // ---------------- director ----------------
    task automatic tick;
        @(posedge iClk); #1;
    endtask

    task automatic do_reset;
        iRst = 1'b0; tick; tick; iRst = 1'b1; tick;
    endtask

    task automatic issue(input logic [31:0] a, input logic le, input logic [31:0] d,
                         input logic h, input logic [31:0] m);
        lit_en[lwr] = le; lit_d[lwr] = d; lit_h[lwr] = h; lit_m[lwr] = m; lwr++;
        iReq = 1'b1; iAddress = a;
        for (int i = 0; i < 1000; i++) begin
            @(negedge iClk);
            if (oReady) break;
        end
        tick;
        iReq = 1'b0;
    endtask

    task automatic wait_resp;
        for (int i = 0; i < 1000; i++) begin
            @(negedge iClk);
            if (oValid) break;
        end
        tick;
    endtask

    task automatic rd_lit(input logic [31:0] a, input logic [31:0] d, input logic h,
                          input logic [31:0] m);
        issue(a, 1'b1, d, h, m);
        wait_resp;
    endtask

    task automatic rd(input logic [31:0] a);
        issue(a, 1'b0, 0, 1'b0, 32'hFFFF_FFFF);
        wait_resp;
    endtask

    task automatic flush(input logic [31:0] a, input logic all);
        iFlush = !all; iFlushAll = all; iFlushAddress = a;
        for (int i = 0; i < 100; i++) begin
            @(negedge iClk);
            if (oFlushAck) break;
        end
        tick;
        iFlush = 1'b0; iFlushAll = 1'b0;
    endtask

    localparam logic [31:0] NONE = 32'hFFFF_FFFF;

    initial begin
        int r;
        logic [31:0] a;
        iRst = 1'b0; iReq = 1'b0; iAddress = '0;
        iFlush = 1'b0; iFlushAll = 1'b0; iFlushAddress = '0;
        repeat (3) tick;
        iRst = 1'b1;
        tick;

        // Basic miss then hit on line 0x040.
        rd_lit(32'h040, 32'h11, 1'b0, 32'h040);
        rd_lit(32'h048, 32'h33, 1'b1, NONE);

        // Three-way conflict in set 4.
        rd_lit(32'h140, mem_word(32'h140), 1'b0, 32'h140);
        rd_lit(32'h240, mem_word(32'h240), 1'b0, 32'h240);
        rd_lit(32'h140, mem_word(32'h140), 1'b1, NONE);
        rd_lit(32'h040, 32'h11, 1'b0, 32'h040);

        // Per-address flush.
        do_reset;
        rd(32'h040);
        rd(32'h140);
        flush(32'h044, 1'b0);
        rd_lit(32'h040, 32'h11, 1'b0, 32'h040);
        rd_lit(32'h140, mem_word(32'h140), 1'b1, NONE);

        // Flush and request in the same cycle: flush first.
        iReq = 1'b1; iAddress = 32'h140;
        flush(32'h140, 1'b0);
        rd_lit(32'h140, mem_word(32'h140), 1'b0, 32'h140);

        // Whole-cache flush.
        flush(32'h0, 1'b1);
        rd_lit(32'h040, 32'h11, 1'b0, 32'h040);
        rd_lit(32'h144, mem_word(32'h144), 1'b0, 32'h140);

        // Gapped refill with a request held throughout.
        resp_gap = 3;
        issue(32'h300, 1'b1, mem_word(32'h300), 1'b0, 32'h300);
        issue(32'h304, 1'b1, mem_word(32'h304), 1'b1, NONE);
        wait_resp;
        resp_gap = -1;

        // Reset in the middle of a refill.
        do_reset;
        beat_limit = 2; resp_gap = 1;
        issue(32'h040, 1'b1, 32'h11, 1'b0, 32'h040);
        for (int i = 0; i < 200; i++) begin
            if (rcnt >= 2) break;
            tick;
        end
        iRst = 1'b0; late_req = late_req + 3;
        tick;
        iRst = 1'b1; beat_limit = -1; resp_gap = -1;
        repeat (6) tick;
        rd_lit(32'h040, 32'h11, 1'b0, 32'h040);
        rd_lit(32'h04C, 32'h44, 1'b1, NONE);

        // Randomized traffic over a small set/tag pool.
        do_reset;
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4)
              | 32'($urandom_range(0, 15));
            if (r < 8)       flush(a, 1'b0);
            else if (r < 10) flush(a, 1'b1);
            else             rd(a);
        end

        repeat (4) tick;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_assoc_rd.md
Name: cache_assoc_rd

Overview:
- Parametrised N-way set-associative read cache; successor to the direct-mapped cache top.
- Sits between the CPU fetch/load path and main memory.
- Serves hits in one cycle and refills misses with a multi-beat line burst over a valid-only memory handshake.
- Supports per-address flush (invalidate) and whole-cache flush; victim selection is invalid-first, then per-set round-robin.

Parameters:
- ADDR_W, 32, address width in bits (byte address).
- DATA_W, 32, word width in bits.
- SETS, 16, number of sets; power of 2, at least 2.
- WAYS, 2, associativity; power of 2, at least 1.
- BLOCK_WORDS, 4, words per line; power of 2, at least 1.

Ports:
- iClk  in  1  clock; all state updates on the rising edge.
- iRst  in  1  synchronous, active-low reset.
- iReq  in  1  read request; taken when iReq && oReady.
- iAddress  in  ADDR_W  byte address of the read; bits [1:0] ignored.
- oReady  out  1  cache can take a request this cycle.
- oValid  out  1  one-cycle pulse; oData is valid.
- oData  out  DATA_W  requested word.
- oHit  out  1  qualified by oValid: 1 = hit, 0 = served after refill.
- iFlush  in  1  invalidate the line holding iFlushAddress; held until oFlushAck.
- iFlushAll  in  1  invalidate every line; held until oFlushAck.
- iFlushAddress  in  ADDR_W  address to invalidate.
- oFlushAck  out  1  one-cycle pulse; flush performed this cycle.
- oMemReq  out  1  line refill request; held high until the last beat.
- oMemAddr  out  ADDR_W  line-aligned refill base address; stable while oMemReq.
- iMemValid  in  1  a refill beat is present on iMemData.
- iMemData  in  DATA_W  refill word; beats arrive in ascending word order.

Behaviour:
- Address split, LSB first:
  - 2 byte bits.
  - WO = log2(BLOCK_WORDS) word-offset bits.
  - IX = log2(SETS) index bits.
  - Tag = ADDR_W - 2 - WO - IX bits.
- Storage per line: valid bit, tag, BLOCK_WORDS data words. Per set: round-robin victim pointer, log2(WAYS) bits.
- FSM states: IDLE, COMPARE, REFILL, RESPOND.
- oReady = (state == IDLE) && !iFlush && !iFlushAll.
- IDLE:
  - iFlushAll takes priority over iFlush, and iFlush over iReq.
  - iFlushAll: clear all valid bits in one cycle; victim pointers unchanged; oFlushAck pulse.
  - iFlush: clear the valid bit of every way in the indexed set whose tag matches and is valid; oFlushAck pulse even if nothing matched.
  - Accepted iReq: register the address; go to COMPARE.
- COMPARE:
  - Compare the registered tag against all ways of the set.
  - Hit (exactly one way, valid and tag-equal): oValid=1, oHit=1, oData = word[WO]; go to IDLE. Hit latency is one cycle after acceptance.
  - Miss: pick the victim (lowest-index invalid way, else the set's pointer); go to REFILL.
- REFILL:
  - oMemReq=1; oMemAddr = registered address with the WO+2 LSBs zeroed.
  - Each iMemValid beat writes word[beat] of the victim way; the beat counter increments.
  - Gaps between beats are allowed. iMemValid outside REFILL is ignored.
  - On the last beat (BLOCK_WORDS-1): write tag, set valid, advance the set's pointer (mod WAYS), go to RESPOND.
  - oMemReq drops in the cycle after the last beat.
- RESPOND: oValid=1, oHit=0, oData = the requested word from the filled line; go to IDLE.
- iReq, iFlush and iFlushAll are not taken outside IDLE; requesters hold them.
- WAYS=1 degenerates to direct-mapped; the pointer is constant 0.
- Reset, including mid-refill:
  - state IDLE; all valid bits 0; pointers 0; beat counter 0.
  - oValid, oHit, oMemReq, oFlushAck = 0; oData = 0; oMemAddr = 0.
  - A partial line is discarded, and late iMemValid beats are ignored.
- Data arrays are not reset.

Test Plan:
- Defaults; after reset, read 0x040 -> oMemReq, oMemAddr=0x040. Beats 0x11,0x22,0x33,0x44 -> one cycle later oValid, oData=0x11, oHit=0. Read 0x048 -> next cycle oData=0x33, oHit=1.
- Conflict in set 4: fill 0x040, 0x140, then 0x240. 0x240 evicts way 0, which holds 0x040. Read 0x140 -> hit. Read 0x040 -> miss with oMemAddr=0x040.
- After filling 0x040 and 0x140: hold iFlush with 0x044 -> one oFlushAck. Read 0x040 -> miss. Read 0x140 -> hit.
- iFlush and iReq asserted in the same IDLE cycle -> oReady=0, flush acked first, request accepted the next cycle. iFlushAll -> every subsequent read misses.
- Refill with 3-cycle gaps between beats -> oMemReq stays high and oMemAddr stays stable, oReady=0 throughout, data correct. iReq held during the refill is accepted only after RESPOND.
- iRst=0 after 2 of 4 beats -> oMemReq=0 next cycle, remaining beats ignored. Read 0x040 -> miss again.
